memarb: RTL and testbench

MEMARB -- requirements
Module: memarb

---
 rtl/memarb_pkg.sv | 20 ++
 rtl/memarbtimer.sv | 27 ++
 rtl/memarb.sv | 130 +++++++++++++
 tb/tb_memarb.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/memarb_pkg.sv
// Shared encodings for the memory arbiter.
// The idle code is shared with the memory controller, so it must remain 2'b00.
package memarb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_GWB  = 2'b01,
      ST_GD   = 2'b10,
      ST_GI   = 2'b11
   } state_e;

   // Picks the read grant in swc order. Call it only when at least one read is pending.
   function automatic state_e pref_rd(input logic swc, input logic dreq, input logic ireq);
      if (swc)
         return ireq ? ST_GI : ST_GD;
      else
         return dreq ? ST_GD : ST_GI;
   endfunction

endpackage

// File: rtl/memarbtimer.sv
// Grant-length counter with clear, enable and a terminal count at TIMEOUT-1.
// The counter stops at terminal count, so it cannot wrap while a grant lingers.
module memarbtimer #(
   parameter int TIMEOUT = 64
) (
   input  logic ph1,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

   logic [CW-1:0] r_tcnt;

   always_ff @(posedge ph1) begin
      if (reset || i_clr)
         r_tcnt <= '0;
      else if (i_en && (r_tcnt != TC_VAL))
         r_tcnt <= r_tcnt + 1'b1;
   end

   assign o_tc = (r_tcnt == TC_VAL);

endmodule

// File: rtl/memarb.sv
// Three-way memory arbiter: a write buffer plus data and instruction reads, with
// read anti-starvation, a one-cycle bus turnaround after writes, and a grant timeout.
module memarb
   import memarb_pkg::*;
#(
   parameter int TIMEOUT     = 64,
   parameter int STARVELIMIT = 4
) (
   input  logic       ph1,
   input  logic       reset,
   input  logic       wbreq,
   input  logic       dreq,
   input  logic       ireq,
   input  logic       swc,
   input  logic       memdone,
   output logic [1:0] state,
   output logic       wbon,
   output logic       don,
   output logic       ion,
   output logic       memen,
   output logic       memrwb,
   output logic       wbdone,
   output logic       ddone,
   output logic       idone,
   output logic       buserr
);

   localparam int SW = $clog2(STARVELIMIT + 1);
   localparam logic [SW-1:0] SLIM = SW'(STARVELIMIT);

   state_e        r_state, w_nxt_state;
   logic          r_turn, w_nxt_turn;
   logic [SW-1:0] r_starvecnt, w_nxt_starve;
   logic          r_wbon, r_don, r_ion, r_memen, r_memrwb, r_buserr;
   logic          w_nxt_wbon, w_nxt_don, w_nxt_ion, w_nxt_memen, w_nxt_memrwb;
   logic          w_ingrant, w_tc, w_tmo, w_fin, w_rdpend, w_starved, w_entry;

   assign w_ingrant = (r_state != ST_IDLE);
   assign w_tmo     = w_ingrant & w_tc & ~memdone;
   assign w_fin     = w_ingrant & (memdone | w_tc);
   assign w_rdpend  = dreq | ireq;
   assign w_starved = (r_starvecnt == SLIM) & w_rdpend;
   assign w_entry   = (r_state == ST_IDLE) & ~r_turn & (w_nxt_state != ST_IDLE);

   memarbtimer #(.TIMEOUT(TIMEOUT)) u_timer (
      .ph1   (ph1),
      .reset (reset),
      .i_clr (w_entry),
      .i_en  (w_ingrant),
      .o_tc  (w_tc)
   );

   always_ff @(posedge ph1) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_turn      <= 1'b0;
         r_starvecnt <= '0;
         r_wbon      <= 1'b0;
         r_don       <= 1'b0;
         r_ion       <= 1'b0;
         r_memen     <= 1'b0;
         r_memrwb    <= 1'b1;
         r_buserr    <= 1'b0;
      end else begin
         r_state     <= w_nxt_state;
         r_turn      <= w_nxt_turn;
         r_starvecnt <= w_nxt_starve;
         r_wbon      <= w_nxt_wbon;
         r_don       <= w_nxt_don;
         r_ion       <= w_nxt_ion;
         r_memen     <= w_nxt_memen;
         r_memrwb    <= w_nxt_memrwb;
         r_buserr    <= w_tmo;
      end
   end

   // TURN keeps the IDLE code and is marked by r_turn; requests are not sampled during it.
   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_turn   = 1'b0;
      w_nxt_starve = r_starvecnt;
      if (r_turn) begin
         w_nxt_state = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (wbreq && !w_starved) begin
                  w_nxt_state = ST_GWB;
                  if (w_rdpend)
                     w_nxt_starve = r_starvecnt + 1'b1;
               end else if (w_rdpend) begin
                  w_nxt_state  = pref_rd(swc, dreq, ireq);
                  w_nxt_starve = '0;
               end
            end
            ST_GWB: begin
               if (w_fin) begin
                  w_nxt_state = ST_IDLE;
                  w_nxt_turn  = 1'b1;
               end
            end
            default: begin
               if (w_fin)
                  w_nxt_state = ST_IDLE;
            end
         endcase
      end
   end

   // Grant outputs are decoded from the next state, so they register together with it.
   always_comb begin
      w_nxt_wbon   = (w_nxt_state == ST_GWB);
      w_nxt_don    = (w_nxt_state == ST_GD);
      w_nxt_ion    = (w_nxt_state == ST_GI);
      w_nxt_memen  = (w_nxt_state != ST_IDLE);
      w_nxt_memrwb = (w_nxt_state != ST_GWB);
   end

   assign state  = r_state;
   assign wbon   = r_wbon;
   assign don    = r_don;
   assign ion    = r_ion;
   assign memen  = r_memen;
   assign memrwb = r_memrwb;
   assign buserr = r_buserr;
   assign wbdone = r_wbon & (memdone | w_tmo);
   assign ddone  = r_don  & (memdone | w_tmo);
   assign idone  = r_ion  & (memdone | w_tmo);

endmodule

// File: tb/tb_memarb.sv
// Directed bench for memarb. Output vector layout:
// {state[1:0], wbon, don, ion, memen, memrwb, buserr}
module tb_memarb;

   logic ph1 = 1'b0;
   logic reset, wbreq, dreq, ireq, swc, memdone;
   logic [1:0] state;
   logic wbon, don, ion, memen, memrwb, wbdone, ddone, idone, buserr;
   logic [7:0] o_vec;
   logic [2:0] d_vec;
   int n_chk = 0;
   int n_fail = 0;

   localparam logic [7:0] V_IDLE = 8'b00_000_0_1_0;
   localparam logic [7:0] V_BERR = 8'b00_000_0_1_1;
   localparam logic [7:0] V_GWB  = 8'b01_100_1_0_0;
   localparam logic [7:0] V_GD   = 8'b10_010_1_1_0;
   localparam logic [7:0] V_GI   = 8'b11_001_1_1_0;

   assign o_vec = {state, wbon, don, ion, memen, memrwb, buserr};
   assign d_vec = {wbdone, ddone, idone};

   memarb #(.TIMEOUT(64), .STARVELIMIT(4)) dut (
      .ph1(ph1), .reset(reset), .wbreq(wbreq), .dreq(dreq), .ireq(ireq),
      .swc(swc), .memdone(memdone), .state(state), .wbon(wbon), .don(don),
      .ion(ion), .memen(memen), .memrwb(memrwb), .wbdone(wbdone),
      .ddone(ddone), .idone(idone), .buserr(buserr)
   );

   always #5 ph1 = ~ph1;

   task automatic tick();
      @(posedge ph1);
      #1;
   endtask

   task automatic test_reset();
      reset = 1; wbreq = 0; dreq = 0; ireq = 0; swc = 0; memdone = 0;
      tick(); tick();
      n_chk++;
      if (o_vec !== V_IDLE) begin n_fail++; $display("FAIL reset_outs got %b want %b", o_vec, V_IDLE); end
      n_chk++;
      if (d_vec !== 3'b000) begin n_fail++; $display("FAIL reset_done got %b want 000", d_vec); end
      reset = 0;
      // memdone must be ignored while idle
      memdone = 1; #1;
      n_chk++;
      if (d_vec !== 3'b000) begin n_fail++; $display("FAIL idle_memdone_done got %b want 000", d_vec); end
      tick();
      memdone = 0;
      n_chk++;
      if (o_vec !== V_IDLE) begin n_fail++; $display("FAIL idle_memdone got %b want %b", o_vec, V_IDLE); end
   endtask

   task automatic test_priority();
      dreq = 1; ireq = 1; swc = 0;
      tick();
      n_chk++;
      if (o_vec !== V_GD) begin n_fail++; $display("FAIL swc0_grant got %b want %b", o_vec, V_GD); end
      dreq = 0; ireq = 0; memdone = 1; #1;
      n_chk++;
      if (d_vec !== 3'b010) begin n_fail++; $display("FAIL swc0_ddone got %b want 010", d_vec); end
      tick();
      memdone = 0;
      n_chk++;
      if (o_vec !== V_IDLE) begin n_fail++; $display("FAIL gd_release got %b want %b", o_vec, V_IDLE); end
      dreq = 1; ireq = 1; swc = 1;
      tick();
      n_chk++;
      if (o_vec !== V_GI) begin n_fail++; $display("FAIL swc1_grant got %b want %b", o_vec, V_GI); end
      dreq = 0; ireq = 0; swc = 0; memdone = 1; #1;
      n_chk++;
      if (d_vec !== 3'b001) begin n_fail++; $display("FAIL swc1_idone got %b want 001", d_vec); end
      tick();
      memdone = 0;
   endtask

   task automatic test_wb_turn();
      wbreq = 1;
      tick();
      n_chk++;
      if (o_vec !== V_GWB) begin n_fail++; $display("FAIL wb_grant got %b want %b", o_vec, V_GWB); end
      wbreq = 0; dreq = 1;
      tick();
      n_chk++;
      if (o_vec !== V_GWB) begin n_fail++; $display("FAIL wb_hold got %b want %b", o_vec, V_GWB); end
      memdone = 1; #1;
      n_chk++;
      if (d_vec !== 3'b100) begin n_fail++; $display("FAIL wbdone got %b want 100", d_vec); end
      tick();
      memdone = 0;
      n_chk++;
      if (o_vec !== V_IDLE) begin n_fail++; $display("FAIL turn_cycle got %b want %b", o_vec, V_IDLE); end
      tick();
      n_chk++;
      if (o_vec !== V_IDLE) begin n_fail++; $display("FAIL post_turn_idle got %b want %b", o_vec, V_IDLE); end
      tick();
      n_chk++;
      if (o_vec !== V_GD) begin n_fail++; $display("FAIL read_after_turn got %b want %b", o_vec, V_GD); end
      dreq = 0; memdone = 1;
      tick();
      memdone = 0;
   endtask

   task automatic test_starve();
      wbreq = 1; dreq = 1; swc = 0;
      tick();
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (o_vec !== V_GWB) begin n_fail++; $display("FAIL starve_wb%0d got %b want %b", i, o_vec, V_GWB); end
         tick();
         memdone = 1;
         tick();
         memdone = 0;
         n_chk++;
         if (o_vec !== V_IDLE) begin n_fail++; $display("FAIL starve_turn%0d got %b want %b", i, o_vec, V_IDLE); end
         tick(); tick();
      end
      n_chk++;
      if (o_vec !== V_GD) begin n_fail++; $display("FAIL starve_read got %b want %b", o_vec, V_GD); end
      memdone = 1; #1;
      n_chk++;
      if (d_vec !== 3'b010) begin n_fail++; $display("FAIL starve_ddone got %b want 010", d_vec); end
      tick();
      memdone = 0;
      tick();
      // counter cleared on the read grant, so the write buffer wins again
      n_chk++;
      if (o_vec !== V_GWB) begin n_fail++; $display("FAIL starve_cleared got %b want %b", o_vec, V_GWB); end
      wbreq = 0; dreq = 0; memdone = 1;
      tick();
      memdone = 0;
      tick();
   endtask

   task automatic test_timeout();
      ireq = 1; swc = 0;
      tick();
      n_chk++;
      if (o_vec !== V_GI) begin n_fail++; $display("FAIL tmo_grant got %b want %b", o_vec, V_GI); end
      ireq = 0;
      for (int k = 0; k < 63; k++) begin
         n_chk++;
         if (d_vec !== 3'b000 || o_vec !== V_GI) begin
            n_fail++; $display("FAIL tmo_early cyc %0d got %b/%b want 000/%b", k, d_vec, o_vec, V_GI);
         end
         tick();
      end
      n_chk++;
      if (d_vec !== 3'b001) begin n_fail++; $display("FAIL tmo_idone got %b want 001", d_vec); end
      tick();
      n_chk++;
      if (o_vec !== V_BERR) begin n_fail++; $display("FAIL tmo_buserr got %b want %b", o_vec, V_BERR); end
      tick();
      n_chk++;
      if (o_vec !== V_IDLE) begin n_fail++; $display("FAIL tmo_buserr_clear got %b want %b", o_vec, V_IDLE); end
   endtask

   task automatic test_done_at_tc();
      dreq = 1;
      tick();
      dreq = 0;
      for (int k = 0; k < 63; k++) tick();
      n_chk++;
      if (o_vec !== V_GD) begin n_fail++; $display("FAIL tc_still_granted got %b want %b", o_vec, V_GD); end
      memdone = 1; #1;
      n_chk++;
      if (d_vec !== 3'b010) begin n_fail++; $display("FAIL tc_ddone got %b want 010", d_vec); end
      tick();
      memdone = 0;
      n_chk++;
      if (o_vec !== V_IDLE) begin n_fail++; $display("FAIL tc_no_buserr got %b want %b", o_vec, V_IDLE); end
      tick();
      n_chk++;
      if (o_vec !== V_IDLE) begin n_fail++; $display("FAIL tc_no_buserr2 got %b want %b", o_vec, V_IDLE); end
   endtask

   task automatic test_reset_mid();
      dreq = 1;
      tick();
      tick(); tick(); tick();
      n_chk++;
      if (o_vec !== V_GD) begin n_fail++; $display("FAIL mid_grant got %b want %b", o_vec, V_GD); end
      reset = 1; #1;
      n_chk++;
      if (d_vec !== 3'b000) begin n_fail++; $display("FAIL mid_rst_done got %b want 000", d_vec); end
      tick();
      n_chk++;
      if (o_vec !== V_IDLE || d_vec !== 3'b000) begin
         n_fail++; $display("FAIL mid_rst_outs got %b/%b want %b/000", o_vec, d_vec, V_IDLE);
      end
      reset = 0;
      tick();
      n_chk++;
      if (o_vec !== V_GD) begin n_fail++; $display("FAIL post_rst_grant got %b want %b", o_vec, V_GD); end
      dreq = 0; memdone = 1;
      tick();
      memdone = 0;
   endtask

   initial begin
      test_reset();
      test_priority();
      test_wb_turn();
      test_starve();
      test_timeout();
      test_done_at_tc();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
